// File: rtl/core_ram_slave_if.sv
// Core-side memory bus: Ibex-style req/gnt/rvalid handshake with byte enables and error flag.
interface core_if;
  logic        req;
  logic        gnt;
  logic        rvalid;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        err;

  modport master (output req, we, be, addr, wdata, input gnt, rvalid, rdata, err);
  modport slave  (input req, we, be, addr, wdata, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/core_ram_slave.sv
// Word-addressed RAM responder on core_if; every grant answers exactly LATENCY cycles later, in order.
// Backpressure: gnt drops while MAX_OUT transactions are outstanding; out-of-range accesses answer err=1.
module core_ram_slave #(
  parameter int unsigned WORDS   = 1024,
  parameter logic [31:0] BASE    = 32'h0000_0000,
  parameter int unsigned LATENCY = 1,
  parameter int unsigned MAX_OUT = 2
) (
  input logic   clk,
  input logic   rst,
  core_if.slave bus
);
  localparam int unsigned   AW      = $clog2(WORDS);
  localparam int unsigned   CW      = $clog2(MAX_OUT + 1);
  localparam logic [31:0]   SPAN    = 32'(WORDS * 4);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUT);

  logic [31:0]        offs;
  logic               hit;
  logic [AW-1:0]      idx;
  logic               gnt_i;
  logic               rsp_vld;
  logic [CW-1:0]      out_cnt;
  logic [31:0]        ram [WORDS];
  logic [LATENCY-1:0] pipe_vld;
  logic [LATENCY-1:0] pipe_err;
  logic [31:0]        pipe_dat [LATENCY];

  assign offs = bus.addr - BASE;
  assign hit  = offs < SPAN;
  assign idx  = offs[AW+1:2];

  // Only the registered count gates the grant, so a same-cycle rvalid never frees a slot early.
  assign gnt_i   = bus.req & ~rst & (out_cnt < CNT_MAX);
  assign rsp_vld = pipe_vld[LATENCY-1];
  assign bus.gnt = gnt_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_cnt <= '0;
    end else if (gnt_i & ~rsp_vld) begin
      out_cnt <= out_cnt + CW'(1);
    end else if (~gnt_i & rsp_vld) begin
      out_cnt <= out_cnt - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_vld <= '0;
    end else begin
      pipe_vld[0] <= gnt_i;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
      end
    end
  end

  // Storage and payload are not reset; the valid bits alone decide what reaches the bus.
  always_ff @(posedge clk) begin
    if (gnt_i & hit & bus.we) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.be[i]) begin
          ram[idx][8*i +: 8] <= bus.wdata[8*i +: 8];
        end
      end
    end
    pipe_err[0] <= ~hit;
    pipe_dat[0] <= (hit & ~bus.we) ? ram[idx] : 32'h0;
    for (int i = 1; i < LATENCY; i++) begin
      pipe_err[i] <= pipe_err[i-1];
      pipe_dat[i] <= pipe_dat[i-1];
    end
  end

  assign bus.rvalid = rsp_vld;
  assign bus.err    = rsp_vld & pipe_err[LATENCY-1];
  assign bus.rdata  = rsp_vld ? pipe_dat[LATENCY-1] : 32'h0;
endmodule
